// File: rtl/spi_slave_stream.sv
// spi_slave_stream: SPI mode-0 slave, MSB first, oversampled by clk_i.
// Bus pins pass through SYNC_STAGES flops and are edge-detected in clk_i.
// Received/transmitted words use valid/ready streams.
// Optional feature macro: SPI_SLAVE_QUAD_EN adds quad_i and 4-lane transfers.
module spi_slave_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_csn_i,
    input  logic                  spi_sdi0_i,
    input  logic                  spi_sdi1_i,
    input  logic                  spi_sdi2_i,
    input  logic                  spi_sdi3_i,
`ifdef SPI_SLAVE_QUAD_EN
    input  logic                  quad_i,
`endif
    output logic                  spi_sdo0_o,
    output logic                  spi_sdo1_o,
    output logic                  spi_sdo2_o,
    output logic                  spi_sdo3_o,
    output logic                  spi_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  eot_o,
    output logic                  overflow_o,
    output logic                  underrun_o
);

    localparam int CW = $clog2(DATA_WIDTH);
`ifdef SPI_SLAVE_QUAD_EN
    localparam int LANES = 4;
`else
    localparam int LANES = 1;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                           state;
    logic [SYNC_STAGES-1:0]           sclk_sync;
    logic [SYNC_STAGES-1:0]           csn_sync;
    logic [SYNC_STAGES-1:0][LANES-1:0] sdi_sync;
    logic                             sclk_prev;
    logic                             csn_prev;
    logic [LANES-1:0]                 sdi_in;
    logic [LANES-1:0]                 sdi;
    logic                             sclk_rise;
    logic                             sclk_fall;
    logic                             csn_rise;
    logic                             csn_fall;
    logic [DATA_WIDTH-1:0]            tx_shift;
    logic [DATA_WIDTH-1:0]            tx_next;
    logic [DATA_WIDTH-2:0]            rx_shift;
    logic [DATA_WIDTH-1:0]            rx_next;
    logic [CW-1:0]                    cnt;
    logic [CW-1:0]                    cnt_last;
    logic                             done;
    logic                             reload;

`ifdef SPI_SLAVE_QUAD_EN
    logic quad;
    assign sdi_in     = {spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i};
    assign rx_next    = quad ? {rx_shift[DATA_WIDTH-5:0], sdi} : {rx_shift, sdi[0]};
    assign tx_next    = quad ? (tx_shift << 4) : (tx_shift << 1);
    assign cnt_last   = quad ? CW'(DATA_WIDTH/4 - 1) : CW'(DATA_WIDTH - 1);
    assign spi_sdo0_o = quad ? tx_shift[DATA_WIDTH-4] : tx_shift[DATA_WIDTH-1];
    assign spi_sdo1_o = quad & tx_shift[DATA_WIDTH-3];
    assign spi_sdo2_o = quad & tx_shift[DATA_WIDTH-2];
    assign spi_sdo3_o = quad & tx_shift[DATA_WIDTH-1];
`else
    logic unused_sdi;
    assign unused_sdi = &{1'b0, spi_sdi1_i, spi_sdi2_i, spi_sdi3_i};
    assign sdi_in     = spi_sdi0_i;
    assign rx_next    = {rx_shift, sdi};
    assign tx_next    = tx_shift << 1;
    assign cnt_last   = CW'(DATA_WIDTH - 1);
    assign spi_sdo0_o = tx_shift[DATA_WIDTH-1];
    assign spi_sdo1_o = 1'b0;
    assign spi_sdo2_o = 1'b0;
    assign spi_sdo3_o = 1'b0;
`endif

    assign sdi       = sdi_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] &  sclk_prev;
    assign csn_rise  =  csn_sync[SYNC_STAGES-1]  & ~csn_prev;
    assign csn_fall  = ~csn_sync[SYNC_STAGES-1]  &  csn_prev;

    // Word boundary on SCLK fall: next tx word replaces the shift instead of shifting.
    assign reload     = (state == SHIFT) && !csn_rise && sclk_fall && done;
    assign spi_oe_o   = (state != IDLE);
    assign tx_ready_o = !rst_i && !clr_i && tx_valid_i &&
                        (((state == LOAD) && !csn_rise) || reload);

    // Pin synchronisers; only rst_i stops them so clr_i keeps edge history coherent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            csn_sync  <= '1;
            sdi_sync  <= '0;
            sclk_prev <= 1'b0;
            csn_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi_in};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            csn_prev  <= csn_sync[SYNC_STAGES-1];
        end
    end

    // Frame FSM, shift registers, rx stream and sticky flags.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state      <= IDLE;
            tx_shift   <= '0;
            rx_shift   <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            eot_o      <= 1'b0;
            overflow_o <= 1'b0;
            underrun_o <= 1'b0;
`ifdef SPI_SLAVE_QUAD_EN
            quad       <= 1'b0;
`endif
        end else begin
            eot_o <= 1'b0;
            if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;
            if (csn_rise) begin
                // End of frame wins over any SCLK edge seen in the same cycle.
                eot_o    <= 1'b1;
                state    <= IDLE;
                cnt      <= '0;
                done     <= 1'b0;
                rx_shift <= '0;
                tx_shift <= '0;
            end else begin
                case (state)
                    IDLE: if (csn_fall) state <= LOAD;
                    LOAD: begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        done     <= 1'b0;
                        tx_shift <= tx_valid_i ? tx_data_i : '0;
                        if (!tx_valid_i) underrun_o <= 1'b1;
`ifdef SPI_SLAVE_QUAD_EN
                        quad     <= quad_i;
`endif
                    end
                    SHIFT: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next[DATA_WIDTH-2:0];
                            if (cnt == cnt_last) begin
                                cnt  <= '0;
                                done <= 1'b1;
                                // An accept in the same cycle frees the slot for the new word.
                                if (!rx_valid_o || rx_ready_i) begin
                                    rx_data_o  <= rx_next;
                                    rx_valid_o <= 1'b1;
                                end else begin
                                    overflow_o <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else if (sclk_fall) begin
                            if (done) begin
                                done     <= 1'b0;
                                tx_shift <= tx_valid_i ? tx_data_i : '0;
                                if (!tx_valid_i) underrun_o <= 1'b1;
                            end else begin
                                tx_shift <= tx_next;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream: table of single-word frames plus
// hand sequences for multi-word frames, overflow, underrun/clear, abort and reset.
module tb_spi_slave_stream;

    localparam int DW = 32;
    localparam int H  = 8;   // clk cycles per SCLK half period

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          sclk = 1'b0;
    logic          csn = 1'b1;
    logic [3:0]    sdi = 4'h0;
    logic          sdo0, sdo1, sdo2, sdo3, oe;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          eot, overflow, underrun;
`ifdef SPI_SLAVE_QUAD_EN
    logic          quad = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int txr_cnt = 0;
    int eot_cnt = 0;
    int rx_cnt = 0;
    logic [DW-1:0] rx_q[$];

    spi_slave_stream #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .spi_sclk_i(sclk), .spi_csn_i(csn),
        .spi_sdi0_i(sdi[0]), .spi_sdi1_i(sdi[1]), .spi_sdi2_i(sdi[2]), .spi_sdi3_i(sdi[3]),
`ifdef SPI_SLAVE_QUAD_EN
        .quad_i(quad),
`endif
        .spi_sdo0_o(sdo0), .spi_sdo1_o(sdo1), .spi_sdo2_o(sdo2), .spi_sdo3_o(sdo3),
        .spi_oe_o(oe),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .eot_o(eot), .overflow_o(overflow), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    // Per-cycle monitor, sampled shortly after the active edge.
    always @(posedge clk) begin
        #1;
        if (tx_ready) txr_cnt++;
        if (eot) eot_cnt++;
        if (rx_valid && rx_ready) begin
            rx_cnt++;
            rx_q.push_back(rx_data);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        @(negedge clk);
    endtask

    // Single-lane frame: bits taken from mosi[127] downward; the final SCLK fall
    // and the CSN rise are driven together.
    task automatic frame(input int nbits, input logic [127:0] mosi, output logic [127:0] miso);
        miso = '0;
        @(negedge clk); csn = 1'b0;
        repeat (H) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            sdi[0] = mosi[127-b];
            repeat (H) @(negedge clk);
            miso = {miso[126:0], sdo0};
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
            if (b == nbits - 1) csn = 1'b1;
        end
        repeat (H) @(negedge clk);
    endtask

`ifdef SPI_SLAVE_QUAD_EN
    task automatic qframe(input logic [31:0] mosi, output logic [31:0] miso);
        miso = '0;
        quad = 1'b1;
        @(negedge clk); csn = 1'b0;
        repeat (H) @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            sdi = mosi[31-4*n -: 4];
            repeat (H) @(negedge clk);
            miso = {miso[27:0], sdo3, sdo2, sdo1, sdo0};
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
            if (n == 7) csn = 1'b1;
        end
        repeat (H) @(negedge clk);
        quad = 1'b0;
    endtask
`endif

    typedef struct {
        logic [31:0] tx;
        logic        txv;
        logic [31:0] mosi;
        logic        rdy;
        logic [31:0] e_miso;
        logic        e_rxv;
        int          e_txr;
        logic        e_und;
        int          e_rx;
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [127:0] miso;
        int t0, e0, r0;

        vt[0] = '{32'hA5A5_0F0F, 1'b1, 32'h1234_5678, 1'b0, 32'hA5A5_0F0F, 1'b1, 1, 1'b0, 0};
        vt[1] = '{32'hFFFF_FFFF, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b1, 0, 1'b1, 0};
        vt[2] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, 0};
        vt[3] = '{32'h8000_0001, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0001, 1'b0, 1, 1'b0, 1};

        // Reset state: every output low.
        repeat (4) @(negedge clk);
        chk("reset_outputs", {sdo3, sdo2, sdo1, sdo0, oe, tx_ready, rx_valid, eot, overflow, underrun, rx_data}, '0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_outputs", {sdo0, oe, tx_ready, rx_valid, eot, overflow, underrun}, '0);

        // Table of single-word frames.
        for (int i = 0; i < 4; i++) begin
            pulse_clr();
            tx_data = vt[i].tx; tx_valid = vt[i].txv; rx_ready = vt[i].rdy;
            t0 = txr_cnt; e0 = eot_cnt; r0 = rx_cnt;
            frame(32, {vt[i].mosi, 96'b0}, miso);
            chk("vec_miso", miso[31:0], vt[i].e_miso);
            chk("vec_rx_data", rx_data, vt[i].mosi);
            chk("vec_rx_valid", rx_valid, vt[i].e_rxv);
            chk("vec_tx_ready_pulses", txr_cnt - t0, vt[i].e_txr);
            chk("vec_eot_pulses", eot_cnt - e0, 1);
            chk("vec_underrun", underrun, vt[i].e_und);
            chk("vec_overflow", overflow, 1'b0);
            chk("vec_rx_xfers", rx_cnt - r0, vt[i].e_rx);
            chk("vec_oe_after", oe, 1'b0);
        end

        // Three words in one frame with the consumer always ready.
        pulse_clr();
        tx_data = 32'hC3C3_3C3C; tx_valid = 1'b1; rx_ready = 1'b1;
        t0 = txr_cnt; r0 = rx_cnt;
        frame(96, {32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'h0}, miso);
        chk("b2b_miso", miso[95:0], {3{32'hC3C3_3C3C}});
        chk("b2b_rx_xfers", rx_cnt - r0, 3);
        chk("b2b_tx_ready_pulses", txr_cnt - t0, 3);
        if (rx_cnt - r0 == 3) begin
            chk("b2b_word0", rx_q[r0], 32'hA000_0001);
            chk("b2b_word1", rx_q[r0+1], 32'hB000_0002);
            chk("b2b_word2", rx_q[r0+2], 32'hC000_0003);
        end
        chk("b2b_stickies", {overflow, underrun}, 2'b00);

        // Tx missing at frame start, then soft clear.
        pulse_clr();
        tx_valid = 1'b0; rx_ready = 1'b1;
        frame(32, {32'h0F0F_0F0F, 96'b0}, miso);
        chk("und_miso", miso[31:0], 32'h0);
        chk("und_flag", underrun, 1'b1);
        pulse_clr();
        chk("und_after_clr", underrun, 1'b0);

        // Frame aborted after 13 bits, then a full word.
        tx_valid = 1'b1; tx_data = 32'h1357_9BDF; rx_ready = 1'b0;
        e0 = eot_cnt;
        frame(13, {32'hFFFF_FFFF, 96'b0}, miso);
        chk("abort_rx_valid", rx_valid, 1'b0);
        chk("abort_eot", eot_cnt - e0, 1);
        frame(32, {32'hDEAD_BEEF, 96'b0}, miso);
        chk("abort_next_word", rx_data, 32'hDEAD_BEEF);
        chk("abort_next_valid", rx_valid, 1'b1);

        // Consumer stalled across two words: first kept, overflow flagged.
        pulse_clr();
        rx_ready = 1'b0;
        frame(64, {32'h1111_1111, 32'h2222_2222, 64'b0}, miso);
        chk("ovf_rx_data", rx_data, 32'h1111_1111);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_rx_valid", rx_valid, 1'b1);

`ifdef SPI_SLAVE_QUAD_EN
        pulse_clr();
        tx_data = 32'h0246_8ACE; rx_ready = 1'b0;
        begin
            logic [31:0] qm;
            qframe(32'h89AB_CDEF, qm);
            chk("quad_rx_data", rx_data, 32'h89AB_CDEF);
            chk("quad_miso", qm, 32'h0246_8ACE);
        end
`endif

        // Reset in the middle of a frame with state and stickies set.
        tx_data = 32'hFFFF_FFFF; tx_valid = 1'b1;
        @(negedge clk); csn = 1'b0;
        repeat (2 * H) @(negedge clk);
        chk("mid_oe", {oe, sdo0}, 2'b11);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_reset_outputs", {sdo3, sdo2, sdo1, sdo0, oe, tx_ready, rx_valid, eot, overflow, underrun, rx_data}, '0);
        csn = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (H) @(negedge clk);
        chk("post_reset_idle", {oe, overflow, rx_valid}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
